// File: rtl/output_buffer_read_burst.sv
// Read-mode output buffer: thermometer-decodes every ADC slice into a code bank on
// capture, then streams a wrap-around range of codes as packed words over valid/ready.
module output_buffer_read_burst #(
  parameter  int NUM_ADC = 128,
  parameter  int THERM_W = 8,
  parameter  int ENC_W   = 4,
  parameter  int BUS_W   = 32,
  localparam int IDX_W   = $clog2(NUM_ADC),
  localparam int LEN_W   = IDX_W + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_ADC*THERM_W-1:0] pim_output_i,
  input  logic                       capture_i,
  input  logic                       legacy_map_i,
  input  logic                       err_clr_i,
  input  logic                       start_i,
  input  logic [IDX_W-1:0]           start_idx_i,
  input  logic [LEN_W-1:0]           len_i,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [BUS_W-1:0]           rd_data_o,
  output logic                       rd_last_o,
  output logic                       busy_o,
  output logic                       code_err_o
);

  localparam int               PER_WORD   = BUS_W / ENC_W;
  localparam logic [LEN_W-1:0] PER_WORD_L = LEN_W'(PER_WORD);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t           state_q;
  logic [ENC_W-1:0] bank_q   [NUM_ADC];
  logic [ENC_W-1:0] dec_code [NUM_ADC];
  logic             dec_err;
  logic [IDX_W-1:0] ptr_q, ptr_next;
  logic [LEN_W-1:0] rem_q;
  logic             code_err_q;
  logic [BUS_W-1:0] word;
  logic             cap_en, start_en, hs;

  // Returns {invalid, code}; an invalid slice always encodes to 0.
  function automatic logic [ENC_W:0] decode_slice(input logic [THERM_W-1:0] t,
                                                  input logic legacy);
    int               k;
    logic             seen_zero;
    logic             bad;
    logic [ENC_W-1:0] code;
    k         = 0;
    seen_zero = 1'b0;
    bad       = 1'b0;
    for (int i = THERM_W - 1; i >= 0; i--) begin
      if (t[i]) begin
        if (seen_zero) bad = 1'b1;
        else           k++;
      end else begin
        seen_zero = 1'b1;
      end
    end
    if (legacy && THERM_W == 8) begin
      case (k)
        0, 1:    code = ENC_W'(9);
        2, 3:    code = ENC_W'(6);
        4:       code = ENC_W'(4);
        5:       code = ENC_W'(3);
        6:       code = ENC_W'(2);
        7:       code = ENC_W'(1);
        default: code = '0;
      endcase
    end else begin
      code = ENC_W'(THERM_W - k);
    end
    if (bad) code = '0;
    return {bad, code};
  endfunction

  always_comb begin
    logic [ENC_W:0] r;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    r        = '0;
    dec_err  = 1'b0;
    dec_code = '{default: '0};
    for (int n = 0; n < NUM_ADC; n++) begin
      r           = decode_slice(pim_output_i[NUM_ADC*THERM_W-1-THERM_W*n -: THERM_W],
                                 legacy_map_i);
      dec_code[n] = r[ENC_W-1:0];
      dec_err     = dec_err | r[ENC_W];
    end
  end

  assign cap_en   = capture_i && (state_q == S_IDLE);
  assign start_en = start_i && (state_q == S_IDLE) && (len_i != '0);
  assign hs       = (state_q == S_BURST) && rd_ready_i;
  assign ptr_next = IDX_W'((int'(ptr_q) + PER_WORD) % NUM_ADC);

  // Word assembly: slot m holds code ptr+m (wrapping), zero beyond the remaining count.
  always_comb begin
    int p;
    p    = 0;
    word = '0;
    for (int m = 0; m < PER_WORD; m++) begin
      p = (int'(ptr_q) + m) % NUM_ADC;
      if (m < int'(rem_q)) word[ENC_W*m +: ENC_W] = bank_q[IDX_W'(p)];
    end
  end

  // NOTE: the bank is reset explicitly because a post-reset burst must read zeros.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < NUM_ADC; n++) bank_q[n] <= '0;
    end else if (cap_en) begin
      for (int n = 0; n < NUM_ADC; n++) bank_q[n] <= dec_code[n];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      code_err_q <= 1'b0;
    end else begin
      if (cap_en && dec_err) code_err_q <= 1'b1;
      else if (err_clr_i)    code_err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start_en) begin
            state_q <= S_BURST;
            ptr_q   <= start_idx_i;
            rem_q   <= len_i;
          end
        end
        S_BURST: begin
          if (hs) begin
            if (rem_q <= PER_WORD_L) begin
              state_q <= S_IDLE;
              rem_q   <= '0;
            end else begin
              rem_q <= rem_q - PER_WORD_L;
              ptr_q <= ptr_next;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_valid_o = (state_q == S_BURST);
  assign busy_o     = (state_q == S_BURST);
  assign rd_data_o  = rd_valid_o ? word : '0;
  assign rd_last_o  = rd_valid_o && (rem_q <= PER_WORD_L);
  assign code_err_o = code_err_q;

endmodule

// File: tb/tb_output_buffer_read_burst.sv
// Self-checking bench for output_buffer_read_burst: decode vector table, hand-written
// corner sequences, and randomized bursts against a pattern-matching reference model.
module tb_output_buffer_read_burst;

  localparam int NUM_ADC  = 128;
  localparam int THERM_W  = 8;
  localparam int ENC_W    = 4;
  localparam int BUS_W    = 32;
  localparam int PER_WORD = BUS_W / ENC_W;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic [NUM_ADC*THERM_W-1:0] pim_output_i;
  logic                       capture_i, legacy_map_i, err_clr_i, start_i, rd_ready_i;
  logic [6:0]                 start_idx_i;
  logic [7:0]                 len_i;
  logic                       rd_valid_o, rd_last_o, busy_o, code_err_o;
  logic [BUS_W-1:0]           rd_data_o;

  int errors = 0;
  int checks = 0;

  logic [3:0] model_bank [NUM_ADC];
  bit         model_err;

  typedef struct {
    logic [7:0] therm;
    bit         leg;
    logic [3:0] code;
    bit         err;
  } vec_t;
  vec_t vecs [16];

  output_buffer_read_burst dut (
    .clk_i(clk_i), .rst_i(rst_i), .pim_output_i(pim_output_i),
    .capture_i(capture_i), .legacy_map_i(legacy_map_i), .err_clr_i(err_clr_i),
    .start_i(start_i), .start_idx_i(start_idx_i), .len_i(len_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .rd_last_o(rd_last_o), .busy_o(busy_o), .code_err_o(code_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_slice(input int n, input logic [7:0] v);
    pim_output_i[NUM_ADC*THERM_W-1-THERM_W*n -: THERM_W] = v;
  endtask

  function automatic logic [7:0] get_slice(input int n);
    return pim_output_i[NUM_ADC*THERM_W-1-THERM_W*n -: THERM_W];
  endfunction

  // Reference: a slice is valid only if it equals one of the nine legal patterns.
  function automatic logic [4:0] ref_code(input logic [7:0] t, input bit leg);
    logic [15:0] w;
    for (int k = 0; k <= 8; k++) begin
      w = 16'hFF00 >> k;
      if (t == w[7:0]) begin
        if (!leg) return {1'b0, 4'(8 - k)};
        case (k)
          0, 1:    return 5'd9;
          2, 3:    return 5'd6;
          4:       return 5'd4;
          5:       return 5'd3;
          6:       return 5'd2;
          7:       return 5'd1;
          default: return 5'd0;
        endcase
      end
    end
    return 5'b1_0000;
  endfunction

  function automatic logic [7:0] rand_slice();
    logic [15:0] w;
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    w = 16'hFF00 >> $urandom_range(0, 8);
    return w[7:0];
  endfunction

  task automatic model_capture(input bit leg);
    logic [4:0] r;
    for (int n = 0; n < NUM_ADC; n++) begin
      r             = ref_code(get_slice(n), leg);
      model_bank[n] = r[3:0];
      if (r[4]) model_err = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_word(input int idx, input int len, input int j);
    logic [31:0] w;
    int pos;
    w = '0;
    for (int m = 0; m < PER_WORD; m++) begin
      pos = j * PER_WORD + m;
      if (pos < len) w[ENC_W*m +: ENC_W] = model_bank[(idx + pos) % NUM_ADC];
    end
    return w;
  endfunction

  task automatic fill_all(input logic [7:0] v);
    for (int n = 0; n < NUM_ADC; n++) set_slice(n, v);
  endtask

  task automatic do_capture(input bit leg);
    capture_i    = 1'b1;
    legacy_map_i = leg;
    model_capture(leg);
    tick();
    capture_i = 1'b0;
    check("capture_err", 32'(code_err_o), 32'(model_err));
  endtask

  task automatic do_err_clr();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    model_err = 1'b0;
    check("err_clr", 32'(code_err_o), 0);
  endtask

  task automatic start_burst(input int idx, input int len);
    start_i     = 1'b1;
    start_idx_i = 7'(idx);
    len_i       = 8'(len);
    tick();
    start_i = 1'b0;
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for the first 3 cycles.
  task automatic run_burst(input int idx, input int len, input int mode,
                           input bit noise, input bit cap_start);
    int nwords, j, cyc;
    bit rdy;
    nwords = (len + PER_WORD - 1) / PER_WORD;
    if (cap_start) begin
      capture_i = 1'b1;
      model_capture(legacy_map_i);
    end
    start_burst(idx, len);
    capture_i = 1'b0;
    if (cap_start) check("cap_start_err", 32'(code_err_o), 32'(model_err));
    check("busy_start", 32'(busy_o), 1);
    j   = 0;
    cyc = 0;
    while (j < nwords) begin
      check("valid", 32'(rd_valid_o), 1);
      if (!rd_valid_o) return;
      check("data", rd_data_o, exp_word(idx, len, j));
      check("last", 32'(rd_last_o), 32'(j == nwords - 1));
      case (mode)
        0:       rdy = 1'b1;
        2:       rdy = (cyc >= 3);
        default: rdy = (cyc > 20 * nwords) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      rd_ready_i = rdy;
      if (noise) begin
        capture_i = 1'($urandom_range(0, 1));
        for (int n = 0; n < NUM_ADC; n++) set_slice(n, 8'($urandom));
      end
      tick();
      if (rdy) j++;
      cyc++;
    end
    rd_ready_i = 1'b0;
    capture_i  = 1'b0;
    check("busy_end", 32'(busy_o), 0);
    check("valid_end", 32'(rd_valid_o), 0);
    check("data_idle", rd_data_o, 0);
  endtask

  initial begin
    int idx, len;
    bit leg;

    vecs[0]  = '{8'hF0, 1'b0, 4'd4, 1'b0};
    vecs[1]  = '{8'h00, 1'b0, 4'd8, 1'b0};
    vecs[2]  = '{8'hFF, 1'b0, 4'd0, 1'b0};
    vecs[3]  = '{8'h80, 1'b0, 4'd7, 1'b0};
    vecs[4]  = '{8'hFE, 1'b0, 4'd1, 1'b0};
    vecs[5]  = '{8'h00, 1'b1, 4'd9, 1'b0};
    vecs[6]  = '{8'h80, 1'b1, 4'd9, 1'b0};
    vecs[7]  = '{8'hC0, 1'b1, 4'd6, 1'b0};
    vecs[8]  = '{8'hE0, 1'b1, 4'd6, 1'b0};
    vecs[9]  = '{8'hF0, 1'b1, 4'd4, 1'b0};
    vecs[10] = '{8'hF8, 1'b1, 4'd3, 1'b0};
    vecs[11] = '{8'hFC, 1'b1, 4'd2, 1'b0};
    vecs[12] = '{8'hFE, 1'b1, 4'd1, 1'b0};
    vecs[13] = '{8'hFF, 1'b1, 4'd0, 1'b0};
    vecs[14] = '{8'h5A, 1'b0, 4'd0, 1'b1};
    vecs[15] = '{8'h7F, 1'b1, 4'd0, 1'b1};

    rst_i = 1'b1; pim_output_i = '0; capture_i = 0; legacy_map_i = 0; err_clr_i = 0;
    start_i = 0; start_idx_i = '0; len_i = '0; rd_ready_i = 0;
    for (int n = 0; n < NUM_ADC; n++) model_bank[n] = '0;
    model_err = 1'b0;
    #1;
    check("rst_valid", 32'(rd_valid_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_last", 32'(rd_last_o), 0);
    check("rst_data", rd_data_o, 0);
    check("rst_err", 32'(code_err_o), 0);
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Bank must read all zero after reset.
    run_burst(0, 128, 0, 0, 0);

    // Decode table: ADC0 carries the vector, all other slices are a valid 0x00.
    for (int i = 0; i < 16; i++) begin
      fill_all(8'h00);
      set_slice(0, vecs[i].therm);
      do_capture(vecs[i].leg);
      check($sformatf("vec%0d_err", i), 32'(code_err_o), 32'(vecs[i].err));
      start_burst(0, 1);
      check($sformatf("vec%0d_code", i), rd_data_o, {28'h0, vecs[i].code});
      check($sformatf("vec%0d_last", i), 32'(rd_last_o), 1);
      rd_ready_i = 1'b1;
      tick();
      rd_ready_i = 1'b0;
      check($sformatf("vec%0d_done", i), 32'(rd_valid_o), 0);
      if (model_err) do_err_clr();
    end

    // Linear full burst at full throughput.
    fill_all(8'hF0);
    do_capture(1'b0);
    start_burst(0, 128);
    check("full_word0", rd_data_o, 32'h44444444);
    rd_ready_i = 1'b0;
    run_burst(0, 128, 0, 0, 0);

    // Legacy map.
    set_slice(0, 8'h00); set_slice(1, 8'h80); set_slice(2, 8'hC0); set_slice(3, 8'hFF);
    do_capture(1'b1);
    start_burst(0, 4);
    check("legacy_word", rd_data_o, 32'h00000699);
    check("legacy_last", 32'(rd_last_o), 1);
    rd_ready_i = 1'b1;
    tick();
    rd_ready_i = 1'b0;
    check("legacy_done", 32'(busy_o), 0);

    // Wrap, partial word and backpressure.
    fill_all(8'hF0);
    set_slice(126, 8'hFE); set_slice(127, 8'hFC);
    for (int n = 0; n < 8; n++) set_slice(n, 8'hF8);
    do_capture(1'b0);
    start_burst(126, 10);
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", 32'(rd_valid_o), 1);
      check("bp_word0", rd_data_o, 32'h33333321);
      check("bp_last0", 32'(rd_last_o), 0);
      tick();
    end
    rd_ready_i = 1'b1;
    check("wrap_word0", rd_data_o, 32'h33333321);
    tick();
    check("wrap_word1", rd_data_o, 32'h00000033);
    check("wrap_last1", 32'(rd_last_o), 1);
    tick();
    rd_ready_i = 1'b0;
    check("wrap_done", 32'(rd_valid_o), 0);
    run_burst(126, 10, 2, 0, 0);

    // Error flag, stored zero, clear, and set-over-clear priority.
    fill_all(8'hF0);
    set_slice(5, 8'h5A);
    do_capture(1'b0);
    check("err_set", 32'(code_err_o), 1);
    run_burst(0, 8, 0, 0, 0);
    do_err_clr();
    capture_i = 1'b1; err_clr_i = 1'b1;
    model_capture(1'b0);
    tick();
    capture_i = 1'b0; err_clr_i = 1'b0;
    check("err_set_wins", 32'(code_err_o), 1);
    do_err_clr();

    // Capture during a burst must not disturb the streamed codes.
    run_burst(3, 100, 1, 1, 0);
    run_burst(0, 128, 0, 0, 0);

    // Capture and start in the same cycle: burst reads the new codes.
    fill_all(8'hC0);
    legacy_map_i = 1'b0;
    run_burst(120, 20, 0, 0, 1);

    // Reset mid-burst.
    fill_all(8'hF0);
    do_capture(1'b0);
    start_burst(0, 128);
    rd_ready_i = 1'b1;
    tick(); tick();
    check("pre_rst_valid", 32'(rd_valid_o), 1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rd_valid_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_last", 32'(rd_last_o), 0);
    check("mid_rst_data", rd_data_o, 0);
    rd_ready_i = 1'b0;
    tick();
    rst_i = 1'b0;
    for (int n = 0; n < NUM_ADC; n++) model_bank[n] = '0;
    model_err = 1'b0;
    tick();
    check("post_rst_idle", 32'(rd_valid_o), 0);
    start_burst(0, 8);
    check("post_rst_word", rd_data_o, 0);
    check("post_rst_last", 32'(rd_last_o), 1);
    rd_ready_i = 1'b1;
    tick();
    rd_ready_i = 1'b0;
    check("post_rst_done", 32'(busy_o), 0);

    // start with len 0 is ignored.
    start_burst(5, 0);
    check("len0_ignored", 32'(busy_o), 0);

    // Randomized captures and bursts.
    for (int it = 0; it < 40; it++) begin
      for (int n = 0; n < NUM_ADC; n++) set_slice(n, rand_slice());
      leg = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, NUM_ADC - 1);
      len = $urandom_range(1, NUM_ADC);
      if ($urandom_range(0, 3) == 0) begin
        legacy_map_i = leg;
        run_burst(idx, len, 1, 1'($urandom_range(0, 1)), 1);
      end else begin
        do_capture(leg);
        run_burst(idx, len, 1, 1'($urandom_range(0, 1)), 0);
      end
      if (model_err && ($urandom_range(0, 1) == 1)) do_err_clr();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_buffer_read_burst.md
# output_buffer_read_burst

Parametrised read-mode output buffer for the PIM macro. It thermometer-decodes every ADC slice of the PIM output bus in one capture cycle and holds all codes in a register bank. On request it streams a contiguous, wrap-around range of codes to the bus side as packed words over a valid/ready handshake. It replaces per-address single-code readout with burst readout, runtime-selectable code mapping and invalid-code detection.

## Interface

- NUM_ADC, 128, number of ADC slices on the PIM output bus
- THERM_W, 8, thermometer bits per ADC slice
- ENC_W, 4, bits per encoded code; must hold THERM_W and 9
- BUS_W, 32, read data width; BUS_W % ENC_W == 0; PER_WORD = BUS_W/ENC_W
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- pim_output_i  in  NUM_ADC*THERM_W  ADC n slice = bits [NUM_ADC*THERM_W-1-THERM_W*n -: THERM_W]
- capture_i  in  1  encode all slices into the bank
- legacy_map_i  in  1  1 = legacy LUT mapping (only when THERM_W==8, else ignored)
- err_clr_i  in  1  clear code_err_o
- start_i  in  1  request burst
- start_idx_i  in  clog2(NUM_ADC)  first ADC index of burst
- len_i  in  clog2(NUM_ADC)+1  codes in burst, 1..NUM_ADC
- rd_valid_o  out  1  rd_data_o valid
- rd_ready_i  in  1  consumer accepts word
- rd_data_o  out  BUS_W  packed codes
- rd_last_o  out  1  final word of burst
- busy_o  out  1  burst in progress
- code_err_o  out  1  sticky invalid-thermometer flag

## Operation

- Valid thermometer: k ones contiguous from slice MSB, rest zero (k = 0..THERM_W).
- Linear map: code = THERM_W - k.
- Legacy map (k→code): 0→9, 1→9, 2→6, 3→6, 4→4, 5→3, 6→2, 7→1, 8→0.
- Invalid slice: code 0 stored; sets code_err_o.
- capture_i in IDLE: all NUM_ADC codes written to the bank at that edge, using legacy_map_i sampled at the same edge.
- capture_i in BURST: ignored; bank, code_err_o unchanged.
- code_err_o: set when a capture sees at least one invalid slice; cleared by err_clr_i; set wins over simultaneous clear.
- FSM IDLE/BURST.
  - IDLE + start_i + len_i != 0 → BURST; latch idx = start_idx_i, remaining = len_i.
  - start_i with len_i == 0, or start_i in BURST: ignored.
- In BURST, word j holds codes idx+j*PER_WORD+m (mod NUM_ADC) for m = 0..PER_WORD-1, with code m at bits [ENC_W*m +: ENC_W].
- Codes beyond remaining are zero-padded.
- Index wraps NUM_ADC-1 → 0.
- Word count = ceil(len/PER_WORD); rd_last_o is high only with the final word.
- On handshake (rd_valid_o & rd_ready_i): pointer += PER_WORD, remaining -= PER_WORD; on the final-word handshake → IDLE.
- Capture and start in the same IDLE cycle: the burst reads the newly captured codes.

## Timing

- Reset: rd_valid_o=0, rd_data_o=0, rd_last_o=0, busy_o=0, code_err_o=0, bank all zero, state IDLE. rst_i mid-burst aborts immediately with no further words.
- Capture latency: 1 edge; code_err_o updates at the same edge.
- Start accepted at edge t. busy_o, rd_valid_o and the first word appear after t, i.e. 1 cycle latency.
- rd_data_o/rd_last_o are driven from bank and pointer; 0 when rd_valid_o=0.
- Handshake:
  - rd_valid_o held while rd_ready_i=0.
  - rd_data_o and rd_last_o stable under backpressure.
  - Throughput: 1 word/cycle with rd_ready_i tied high.
- busy_o and rd_valid_o drop the cycle after the final handshake. A new start is accepted from that cycle.

## Test plan

- Reset mid-burst: assert rst_i during word 3 of a 16-word burst → valid/busy/last/data 0 immediately. After release, start idx 0 len 8 → one word 0x00000000, rd_last_o=1.
- Linear full burst: all slices 8'hF0, capture, start idx 0 len 128, ready high → 16 consecutive words 0x44444444, rd_last_o only on word 16, busy_o low the next cycle.
- Legacy map: ADC0..3 = 0x00, 0x80, 0xC0, 0xFF, legacy_map_i=1, capture, start 0 len 4 → single word 0x00000699, rd_last_o=1.
- Wrap and partial: ADC126=0xFE, ADC127=0xFC, ADC0..7=0xF8, linear map, start idx 126 len 10 → word0 0x33333321, word1 0x00000033 with rd_last_o.
- Backpressure: rd_ready_i low 3 cycles on word0 of the previous case → rd_valid_o held and data stable all 3 cycles. Then words 0x33333321, 0x00000033 in order with no loss or duplication.
- Error and capture lock:
  - ADC5=0x5A, capture → code_err_o=1 next cycle, ADC5 reads 0.
  - err_clr_i → 0.
  - capture_i asserted during a burst leaves the streamed codes unchanged.
